// File: rtl/muller_c_proj_formal_top.sv
// Synchronous Muller C-element wrapper for the muller_c project.
// The 2/3-input C-element state sits next to a wrapping transition counter,
// registered rise/fall cover pulses and a sticky consistency monitor.
// The monitor re-derives every state change from the inputs of the
// previous cycle.
module muller_c_proj_formal_top #(
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [5:0]       io_in,
  output logic             c_out,
  output logic             c_out_n,
  output logic [CNT_W-1:0] trans_count,
  output logic             cov_rise,
  output logic             cov_fall,
  output logic             violation
);

  // Pad decode of the current inputs.
  logic [2:0] data_in;
  logic       mode3_in;
  logic       clr_in;
  logic       en_in;

  assign data_in  = io_in[2:0];
  assign mode3_in = io_in[3];
  assign clr_in   = io_in[4];
  assign en_in    = io_in[5];

  // Registered state.
  logic             state_q, state_d;
  logic             state_n_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             prev_q;
  logic [5:0]       shadow_q;
  logic             shadow_vld_q;
  logic             viol_q, viol_d;

  // Shadow decode: the inputs that produced the current state.
  logic [2:0] sh_data;
  logic       sh_mode3;
  logic       sh_clr;
  logic       sh_en;

  assign sh_data  = shadow_q[2:0];
  assign sh_mode3 = shadow_q[3];
  assign sh_clr   = shadow_q[4];
  assign sh_en    = shadow_q[5];

  // Per-input agreement terms. An input that is not part of the active set
  // (c while mode3=0) counts as agreeing with both polarities.
  logic [2:0] act_mask, sh_act_mask;
  logic [2:0] cur_one, cur_zero;
  logic [2:0] sh_one, sh_zero;

  assign act_mask    = {mode3_in, 2'b11};
  assign sh_act_mask = {sh_mode3, 2'b11};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_agree
      assign cur_one[gi]  =  data_in[gi] | ~act_mask[gi];
      assign cur_zero[gi] = ~data_in[gi] | ~act_mask[gi];
      assign sh_one[gi]   =  sh_data[gi] | ~sh_act_mask[gi];
      assign sh_zero[gi]  = ~sh_data[gi] | ~sh_act_mask[gi];
    end
  endgenerate

  logic all_one, all_zero;
  assign all_one  = &cur_one;
  assign all_zero = &cur_zero;

  // Next C-element state: clear beats enable, disagreement holds.
  always_comb begin
    state_d = state_q;
    if (clr_in) begin
      state_d = 1'b0;
    end else if (en_in) begin
      if (all_one) begin
        state_d = 1'b1;
      end else if (all_zero) begin
        state_d = 1'b0;
      end
    end
  end

  // Transition bookkeeping: counter step and the cover pulses for this edge.
  always_comb begin
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (state_d != state_q) begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      rise_d = state_d;
      fall_d = ~state_d;
    end
  end

  // Monitor: a change of the state is legal only when the shadowed inputs
  // forced it (clear, or enable with every active input at the new value).
  logic sh_justified;
  always_comb begin
    sh_justified = sh_clr | (sh_en & (state_q ? (&sh_one) : (&sh_zero)));
    viol_d       = viol_q;
    if (shadow_vld_q && (state_q != prev_q) && !sh_justified) begin
      viol_d = 1'b1;
    end
  end

  // State, complement, counter and cover pulses, all reset synchronously.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= 1'b0;
      state_n_q <= 1'b1;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      state_n_q <= ~state_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // Shadow of last cycle's inputs and state for the monitor; the valid
  // flag keeps the first post-reset cycle from being judged against
  // stale inputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      prev_q       <= 1'b0;
      viol_q       <= 1'b0;
    end else begin
      shadow_q     <= io_in;
      shadow_vld_q <= 1'b1;
      prev_q       <= state_q;
      viol_q       <= viol_d;
    end
  end

  assign c_out       = state_q;
  assign c_out_n     = state_n_q;
  assign trans_count = cnt_q;
  assign cov_rise    = rise_q;
  assign cov_fall    = fall_q;
  assign violation   = viol_q;

`ifdef FORMAL
  // Safety properties and reachability covers for BMC/cover runs.
  always @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      assert (c_out_n == ~c_out);
      assert (!(cov_rise && cov_fall));
      assert (!violation);
      cover (cov_rise);
      cover (cov_fall);
      cover (trans_count == CNT_W'(2));
    end
  end
`endif

endmodule

// File: tb/tb_muller_c_proj_formal_top.sv
// Bench for muller_c_proj_formal_top: directed vector table, counter-wrap
// and mid-sequence reset sequences, then a random run against a reference
// model. Expected results go through a scoreboard queue.
module tb_muller_c_proj_formal_top;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [5:0]       io;
  logic             c_out;
  logic             c_out_n;
  logic [CNT_W-1:0] trans_count;
  logic             cov_rise;
  logic             cov_fall;
  logic             violation;

  muller_c_proj_formal_top #(.CNT_W(CNT_W)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .io_in       (io),
    .c_out       (c_out),
    .c_out_n     (c_out_n),
    .trans_count (trans_count),
    .cov_rise    (cov_rise),
    .cov_fall    (cov_fall),
    .violation   (violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] io;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state.
  logic             m_c;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_step(input logic r, input logic [5:0] v, output exp_t e);
    logic nxt;
    logic a, b, c, m3, clr, en, ones, zeros;
    a = v[0]; b = v[1]; c = v[2]; m3 = v[3]; clr = v[4]; en = v[5];
    ones  = a & b & (c | ~m3);
    zeros = ~a & ~b & (~c | ~m3);
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (r) begin
      m_c   = 1'b0;
      m_cnt = '0;
    end else begin
      if (clr)             nxt = 1'b0;
      else if (!en)        nxt = m_c;
      else if (ones)       nxt = 1'b1;
      else if (zeros)      nxt = 1'b0;
      else                 nxt = m_c;
      if (nxt != m_c) begin
        m_cnt  = m_cnt + 1'b1;
        e.rise = nxt;
        e.fall = ~nxt;
      end
      m_c = nxt;
    end
    e.c   = m_c;
    e.cnt = m_cnt;
  endtask

  // Drive one transaction, queue its expectation, compare one cycle later.
  task automatic apply(input logic r, input logic [5:0] v, input exp_t e,
                       input string tag, input bit verbose);
    exp_t x;
    @(negedge clk);
    rst = r;
    io  = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    if (c_out !== x.c || c_out_n !== ~x.c || trans_count !== x.cnt ||
        cov_rise !== x.rise || cov_fall !== x.fall || violation !== 1'b0) begin
      failures++;
      $display("FAIL %s rst=%b io=%b got c=%b cn=%b cnt=%0d r=%b f=%b v=%b exp c=%b cn=%b cnt=%0d r=%b f=%b v=0",
               tag, r, v, c_out, c_out_n, trans_count, cov_rise, cov_fall, violation,
               x.c, ~x.c, x.cnt, x.rise, x.fall);
    end else if (verbose) begin
      $display("txn %s rst=%b io=%b c=%b cnt=%0d rise=%b fall=%b ok",
               tag, r, v, c_out, trans_count, cov_rise, cov_fall);
    end
  endtask

  vec_t tbl[19];
  exp_t e;

  initial begin
    rst = 1'b1;
    io  = 6'b000000;
    m_c = 1'b0;
    m_cnt = '0;

    //              rst   io          c     cnt  rise  fall
    tbl[0]  = '{1'b1, 6'b000000, '{1'b0, 8'd0, 1'b0, 1'b0}};
    tbl[1]  = '{1'b0, 6'b110001, '{1'b0, 8'd0, 1'b0, 1'b0}};
    tbl[2]  = '{1'b0, 6'b100011, '{1'b1, 8'd1, 1'b1, 1'b0}};
    tbl[3]  = '{1'b0, 6'b100001, '{1'b1, 8'd1, 1'b0, 1'b0}};
    tbl[4]  = '{1'b0, 6'b100001, '{1'b1, 8'd1, 1'b0, 1'b0}};
    tbl[5]  = '{1'b0, 6'b100001, '{1'b1, 8'd1, 1'b0, 1'b0}};
    tbl[6]  = '{1'b0, 6'b100001, '{1'b1, 8'd1, 1'b0, 1'b0}};
    tbl[7]  = '{1'b0, 6'b100001, '{1'b1, 8'd1, 1'b0, 1'b0}};
    tbl[8]  = '{1'b0, 6'b100000, '{1'b0, 8'd2, 1'b0, 1'b1}};
    tbl[9]  = '{1'b0, 6'b000011, '{1'b0, 8'd2, 1'b0, 1'b0}};
    tbl[10] = '{1'b0, 6'b101011, '{1'b0, 8'd2, 1'b0, 1'b0}};
    tbl[11] = '{1'b0, 6'b101111, '{1'b1, 8'd3, 1'b1, 1'b0}};
    tbl[12] = '{1'b0, 6'b101100, '{1'b1, 8'd3, 1'b0, 1'b0}};
    tbl[13] = '{1'b0, 6'b111111, '{1'b0, 8'd4, 1'b0, 1'b1}};
    tbl[14] = '{1'b0, 6'b001000, '{1'b0, 8'd4, 1'b0, 1'b0}};
    tbl[15] = '{1'b0, 6'b100011, '{1'b1, 8'd5, 1'b1, 1'b0}};
    tbl[16] = '{1'b0, 6'b101011, '{1'b1, 8'd5, 1'b0, 1'b0}};
    tbl[17] = '{1'b0, 6'b000000, '{1'b1, 8'd5, 1'b0, 1'b0}};
    tbl[18] = '{1'b1, 6'b100011, '{1'b0, 8'd0, 1'b0, 1'b0}};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].rst, tbl[i].io, tbl[i].e, $sformatf("vec%0d", i), 1'b1);
    end

    // Model resynchronised: the table ended in reset.
    m_c   = 1'b0;
    m_cnt = '0;

    // 256 toggles wrap the counter back to zero.
    for (int i = 0; i < 256; i++) begin
      logic [5:0] v;
      v = (i % 2 == 0) ? 6'b100011 : 6'b100000;
      model_step(1'b0, v, e);
      apply(1'b0, v, e, $sformatf("wrap%0d", i), (i >= 254));
    end
    e = '{1'b0, 8'd0, 1'b0, 1'b0};
    apply(1'b0, 6'b000000, e, "wrap_end_zero", 1'b1);

    // Mid-sequence reset while a=b=1 with enable: reset wins.
    for (int i = 0; i < 7; i++) begin
      logic [5:0] v;
      v = (i % 2 == 0) ? 6'b100011 : 6'b100000;
      model_step(1'b0, v, e);
      apply(1'b0, v, e, $sformatf("pre_rst%0d", i), 1'b1);
    end
    e = '{1'b0, 8'd0, 1'b0, 1'b0};
    apply(1'b1, 6'b100011, e, "mid_reset", 1'b1);
    m_c   = 1'b0;
    m_cnt = '0;

    // Random traffic against the model; rare resets mixed in.
    for (int i = 0; i < 10000; i++) begin
      logic       r;
      logic [5:0] v;
      r = ($urandom_range(0, 199) == 0);
      v = 6'($urandom_range(0, 63));
      model_step(r, v, e);
      apply(r, v, e, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
